// File: rtl/gcd_result_buffer.sv
// gcd_result_buffer
// Captures each result from an upstream GCD FSM exactly once. A two-state
// handshake FSM acknowledges the capture, and a 4-entry show-ahead circular
// FIFO hands results downstream with valid/ready flow control.
module gcd_result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] result_in,
  output logic             result_taken,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       count,
  output logic             full,
  output logic [7:0]       results_total
);

  localparam int AW = 2;

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [7:0]       total_q, total_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push;
  logic pop;

  // Full is taken from the registered count, so a pop on the same edge
  // never frees a slot for a push until the following cycle.
  assign full          = (count_q == 3'(DEPTH));
  assign out_valid     = (count_q != 3'd0);
  assign push          = (state_q == ST_WAIT) && result_valid && !full;
  assign pop           = out_valid && out_ready;
  assign result_taken  = (state_q == ST_ACK);
  assign out_data      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count         = count_q;
  assign results_total = total_q;

  // Capture FSM: one ACK cycle per push, ACK never writes.
  always_comb begin
    state_d = ST_WAIT;
    case (state_q)
      ST_WAIT: state_d = push ? ST_ACK : ST_WAIT;
      ST_ACK:  state_d = ST_WAIT;
      default: state_d = ST_WAIT;
    endcase
  end

  // FIFO pointer, occupancy and capture-counter next-state logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    total_d  = total_q + 8'(push);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous reset; reset discards any queued data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_WAIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      total_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      total_q  <= total_d;
    end
  end

  // Storage array, written on push only; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= result_in;
    end
  end

endmodule
